column_cursor_ctrl: RTL

Consumer end of the pushbutton debouncer interface.
- Takes the debounced strobes (DPB, SCEN, MCEN) from three debouncer instances: LEFT, RIGHT and DROP.
- Converts them into Connect Four actions: cursor movement with auto-repeat, and a drop request handshake to the board-update logic.
- Tracks whose turn it is.
- Sits between the debouncers and the board/VGA logic.

---
 rtl/connect_four_pkg.sv | 16 +
 rtl/wrap_counter.sv | 31 +++
 rtl/column_cursor_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/connect_four_pkg.sv
// Shared Connect Four definitions: board geometry, controller states, player ids.
package connect_four_pkg;

    localparam int NCOLS = 7;
    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WREL = 2'b10
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-NCOLS up/down counter with enable; wraps at both ends.
// One-cycle latency from inc/dec to count; no backpressure.
module wrap_counter #(
    parameter int NCOLS = 7,
    parameter int COL_W = 3,
    parameter int INIT  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [COL_W-1:0] count
);

    localparam logic [COL_W-1:0] LAST = COL_W'(NCOLS - 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= COL_W'(INIT);
        end else if (en) begin
            // inc and dec together cancel out
            if (inc && !dec) begin
                count <= (count == LAST) ? '0 : count + COL_W'(1);
            end else if (dec && !inc) begin
                count <= (count == '0) ? LAST : count - COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/column_cursor_ctrl.sv
// Turns debounced LEFT/RIGHT/DROP strobes into cursor moves and a drop request/ack handshake.
// Registered outputs, one-cycle latency; DROP_REQ is held until DROP_ACK, then waits for drop button release.
module column_cursor_ctrl #(
    parameter int NCOLS    = connect_four_pkg::NCOLS,
    parameter int COL_W    = connect_four_pkg::COL_W,
    parameter int INIT_COL = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             GAME_EN,
    input  logic             L_SCEN,
    input  logic             L_MCEN,
    input  logic             R_SCEN,
    input  logic             R_MCEN,
    input  logic             D_DPB,
    input  logic             D_SCEN,
    input  logic [NCOLS-1:0] COL_FULL,
    input  logic             DROP_ACK,
    output logic [COL_W-1:0] CURSOR,
    output logic             DROP_REQ,
    output logic [COL_W-1:0] DROP_COL,
    output logic             PLAYER,
    output logic             REJECT,
    output logic             BUSY
);

    import connect_four_pkg::*;

    state_t state;
    logic   mv_l;
    logic   mv_r;
    logic   move_en;
    logic   cur_full;

    assign mv_l = L_SCEN | L_MCEN;
    assign mv_r = R_SCEN | R_MCEN;

    // A drop strobe suppresses any move in the same cycle so the drop sees the pre-move column.
    assign move_en = (state == IDLE) && GAME_EN && !D_SCEN;

    always_comb begin
        cur_full = 1'b0;
        for (int i = 0; i < NCOLS; i++) begin
            if (CURSOR == COL_W'(i)) begin
                cur_full = COL_FULL[i];
            end
        end
    end

    wrap_counter #(
        .NCOLS (NCOLS),
        .COL_W (COL_W),
        .INIT  (INIT_COL)
    ) u_cursor (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (move_en),
        .inc   (mv_r),
        .dec   (mv_l),
        .count (CURSOR)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            DROP_REQ <= 1'b0;
            DROP_COL <= '0;
            PLAYER   <= P1;
            REJECT   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            REJECT <= 1'b0;
            case (state)
                IDLE: begin
                    if (GAME_EN && D_SCEN) begin
                        BUSY <= 1'b1;
                        if (!cur_full) begin
                            DROP_COL <= CURSOR;
                            DROP_REQ <= 1'b1;
                            state    <= REQ;
                        end else begin
                            REJECT <= 1'b1;
                            state  <= WREL;
                        end
                    end
                end
                REQ: begin
                    if (DROP_ACK) begin
                        DROP_REQ <= 1'b0;
                        PLAYER   <= (PLAYER == P1) ? P2 : P1;
                        state    <= WREL;
                    end
                end
                WREL: begin
                    if (!D_DPB) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
